servant_uart_loader: RTL and testbench

- Serial bootloader for servant. Receives a program image over a UART RX line and writes it into servant_ram as a Wishbone initiator.
- Holds the CPU in reset until the image is complete.
- Sits between the board RX pin and the RAM port.
- Muxed against the CPU memory bus while o_cpu_rst is high.

---
 rtl/servant_uart_loader.sv | 198 +++++++++++++++++++
 tb/tb_servant_uart_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_loader.sv
// Serial bootloader: receives a length-prefixed word image over UART 8N1 and writes it
// into RAM as a Wishbone initiator, holding the CPU in reset until the image is loaded.
module servant_uart_loader #(
    parameter int unsigned DIVISOR = 16,
    parameter int unsigned MEMSIZE = 8192,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        i_rx,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_err
);
    localparam logic [31:0] WORDS     = 32'(MEMSIZE / 4);
    localparam logic [15:0] HALF_BIT  = 16'(DIVISOR / 2 - 1);
    localparam logic [15:0] FULL_BIT  = 16'(DIVISOR - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_WRITE, LD_DONE} ld_state_t;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] bit_timer;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic        byte_valid, frame_err;

    ld_state_t   ld_state;
    logic        hold_full;
    logic [7:0]  hold_byte;
    logic [15:0] word_count, word_idx;
    logic [1:0]  byte_cnt;
    logic        take;
    logic [15:0] new_count;

    assign o_wb_sel  = 4'hF;
    assign o_wb_we   = o_wb_cyc;
    // The loader never consumes while a write is outstanding; bytes wait in the holding register.
    assign take      = hold_full && (ld_state != LD_WRITE);
    assign new_count = {hold_byte, word_count[7:0]};

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_timer  <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= i_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state  <= RX_START;
                        bit_timer <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (bit_timer == '0) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state  <= RX_DATA;
                            bit_timer <= FULL_BIT;
                            bit_idx   <= '0;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_timer == '0) begin
                        rx_shift  <= {rx_sync, rx_shift[7:1]};
                        bit_timer <= FULL_BIT;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_timer == '0) begin
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ld_state   <= LD_LEN0;
            hold_full  <= 1'b0;
            hold_byte  <= '0;
            word_count <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            o_wb_adr   <= BASE;
            o_wb_dat   <= '0;
            o_wb_cyc   <= 1'b0;
            o_cpu_rst  <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            // A byte consumed this cycle frees the slot for one landing in the same cycle.
            if (byte_valid) begin
                if (hold_full && !take) begin
                    o_err <= 1'b1;
                end else begin
                    hold_byte <= rx_byte;
                    hold_full <= 1'b1;
                end
            end else if (take) begin
                hold_full <= 1'b0;
            end
            if (frame_err) o_err <= 1'b1;

            case (ld_state)
                LD_LEN0: begin
                    if (take) begin
                        word_count[7:0] <= hold_byte;
                        ld_state        <= LD_LEN1;
                    end
                end
                LD_LEN1: begin
                    if (take) begin
                        word_count[15:8] <= hold_byte;
                        byte_cnt         <= '0;
                        if (new_count == '0) begin
                            ld_state  <= LD_DONE;
                            o_done    <= 1'b1;
                            o_cpu_rst <= 1'b0;
                        end else if (32'(new_count) > WORDS) begin
                            o_err     <= 1'b1;
                            ld_state  <= LD_DONE;
                            o_done    <= 1'b1;
                            o_cpu_rst <= 1'b0;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (take) begin
                        o_wb_dat <= {hold_byte, o_wb_dat[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            ld_state <= LD_WRITE;
                            o_wb_cyc <= 1'b1;
                        end
                    end
                end
                LD_WRITE: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        word_idx <= word_idx + 16'd1;
                        o_wb_adr <= o_wb_adr + 32'd4;
                        if (word_idx + 16'd1 == word_count) begin
                            ld_state  <= LD_DONE;
                            o_done    <= 1'b1;
                            o_cpu_rst <= 1'b0;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DONE: ;
                default: ld_state <= LD_LEN0;
            endcase
        end
    end
endmodule

// File: tb/tb_servant_uart_loader.sv
// Directed bench for servant_uart_loader: UART frames in, Wishbone writes logged and compared.
module tb_servant_uart_loader;
    localparam int DIV = 16;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        i_rx = 1'b1;
    logic        i_wb_ack = 1'b0;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_cpu_rst, o_done, o_err;

    int n_tests = 0;
    int n_fail = 0;
    int ack_delay = 1;
    int wait_cnt = 0;
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          wr_len[$];
    int          cyc_len = 0;
    logic [31:0] prev_adr = '0;
    logic [31:0] prev_dat = '0;
    int          unstable = 0;
    int          bad_ctl = 0;
    int          cyc_seen = 0;

    servant_uart_loader #(.DIVISOR(DIV), .MEMSIZE(8192), .BASE(32'h0)) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .i_rx     (i_rx),
        .o_wb_adr (o_wb_adr),
        .o_wb_dat (o_wb_dat),
        .o_wb_sel (o_wb_sel),
        .o_wb_we  (o_wb_we),
        .o_wb_cyc (o_wb_cyc),
        .i_wb_ack (i_wb_ack),
        .o_cpu_rst(o_cpu_rst),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder: ack after ack_delay wait states, one-cycle pulse.
    always @(negedge wb_clk) begin
        if (i_wb_ack) begin
            i_wb_ack = 1'b0;
        end else if (o_wb_cyc) begin
            if (wait_cnt >= ack_delay) begin
                i_wb_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(posedge wb_clk) begin
        if (o_wb_cyc && !wb_rst) begin
            cyc_seen++;
            if (cyc_len > 0 && (o_wb_adr !== prev_adr || o_wb_dat !== prev_dat)) unstable++;
            if (o_wb_sel !== 4'hF || o_wb_we !== 1'b1) bad_ctl++;
            cyc_len++;
            prev_adr = o_wb_adr;
            prev_dat = o_wb_dat;
            if (i_wb_ack) begin
                wr_adr.push_back(o_wb_adr);
                wr_dat.push_back(o_wb_dat);
                wr_len.push_back(cyc_len);
                cyc_len = 0;
            end
        end else begin
            cyc_len = 0;
        end
    end

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        wr_len.delete();
        unstable = 0;
        bad_ctl = 0;
        cyc_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge wb_clk);
        wb_rst = 1'b1;
        i_rx = 1'b1;
        repeat (3) @(negedge wb_clk);
        clear_log();
        wb_rst = 1'b0;
        repeat (2) @(negedge wb_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        repeat (DIV) @(negedge wb_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (DIV) @(negedge wb_clk);
        end
        i_rx = stop;
        repeat (DIV) @(negedge wb_clk);
        i_rx = 1'b1;
        if (!stop) repeat (DIV) @(negedge wb_clk);
    endtask

    task automatic send_count(input logic [15:0] c);
        send_byte(c[7:0], 1'b1);
        send_byte(c[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(negedge wb_clk);
            n++;
        end
        check(tag, {31'd0, o_done}, 32'd1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] adr,
                               input logic [31:0] dat);
        if (idx < wr_adr.size()) begin
            check({tag, "_adr"}, wr_adr[idx], adr);
            check({tag, "_dat"}, wr_dat[idx], dat);
        end else begin
            check({tag, "_missing"}, 32'(wr_adr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int n;
        // Reset state
        do_reset();
        check("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("rst_we", {31'd0, o_wb_we}, 32'd0);
        check("rst_adr", o_wb_adr, 32'h0);
        check("rst_dat", o_wb_dat, 32'h0);
        check("rst_sel", {28'd0, o_wb_sel}, 32'hF);
        check("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);

        // Two-word image, 1 wait state
        ack_delay = 1;
        send_count(16'd2);
        check("t1_busy_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        send_word(32'hDEADBEEF);
        send_word(32'h00000013);
        wait_done("t1_done", 200);
        check("t1_nwr", 32'(wr_adr.size()), 32'd2);
        check_write("t1_w0", 0, 32'h0, 32'hDEADBEEF);
        check_write("t1_w1", 1, 32'h4, 32'h00000013);
        if (wr_len.size() > 0) check("t1_cyc_len", 32'(wr_len[0]), 32'd2);
        check("t1_bad_ctl", 32'(bad_ctl), 32'd0);
        check("t1_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
        check("t1_err", {31'd0, o_err}, 32'd0);

        // Zero count: done right after the second stop bit, no cycle
        do_reset();
        send_count(16'd0);
        check("t2_done", {31'd0, o_done}, 32'd1);
        check("t2_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
        check("t2_no_cyc", 32'(cyc_seen), 32'd0);
        check("t2_err", {31'd0, o_err}, 32'd0);

        // Over capacity (2049 > 2048 words)
        do_reset();
        send_count(16'h0801);
        repeat (4) @(negedge wb_clk);
        check("t3_err", {31'd0, o_err}, 32'd1);
        check("t3_done", {31'd0, o_done}, 32'd1);
        check("t3_no_cyc", 32'(cyc_seen), 32'd0);

        // 3 wait states: cycle lasts 4 clocks with stable adr/dat
        do_reset();
        ack_delay = 3;
        send_count(16'd1);
        send_word(32'h12345678);
        wait_done("t4_done", 200);
        check_write("t4_w0", 0, 32'h0, 32'h12345678);
        if (wr_len.size() > 0) check("t4_cyc_len", 32'(wr_len[0]), 32'd4);
        check("t4_unstable", 32'(unstable), 32'd0);

        // Long write so the next byte lands in the holding register during WRITE
        do_reset();
        ack_delay = 200;
        send_count(16'd2);
        send_word(32'hA5A50102);
        send_word(32'h0BADF00D);
        wait_done("t5_done", 2000);
        check("t5_nwr", 32'(wr_adr.size()), 32'd2);
        check_write("t5_w0", 0, 32'h0, 32'hA5A50102);
        check_write("t5_w1", 1, 32'h4, 32'h0BADF00D);
        check("t5_unstable", 32'(unstable), 32'd0);
        check("t5_err", {31'd0, o_err}, 32'd0);

        // Framing error on the 3rd data byte: byte dropped, word shifts
        do_reset();
        ack_delay = 1;
        send_count(16'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        check("t6_err_early", {31'd0, o_err}, 32'd1);
        check("t6_no_cyc_yet", 32'(cyc_seen), 32'd0);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        wait_done("t6_done", 200);
        check_write("t6_w0", 0, 32'h0, 32'h55442211);

        // Reset mid-WRITE, then a fresh load from BASE
        do_reset();
        ack_delay = 1000;
        send_byte(8'h77, 1'b0);
        send_count(16'd1);
        send_word(32'h01020304);
        n = 0;
        while (!o_wb_cyc && n < 3000) begin
            @(negedge wb_clk);
            n++;
        end
        check("t7_in_write", {31'd0, o_wb_cyc}, 32'd1);
        check("t7_err_before", {31'd0, o_err}, 32'd1);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        check("t7_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("t7_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        check("t7_done", {31'd0, o_done}, 32'd0);
        check("t7_err", {31'd0, o_err}, 32'd0);
        ack_delay = 1;
        clear_log();
        wb_rst = 1'b0;
        repeat (2) @(negedge wb_clk);
        send_count(16'd1);
        send_word(32'hCAFEF00D);
        wait_done("t7_done2", 200);
        check("t7_nwr", 32'(wr_adr.size()), 32'd1);
        check_write("t7_w0", 0, 32'h0, 32'hCAFEF00D);

        // Short low glitch between bytes: ignored
        do_reset();
        send_byte(8'h01, 1'b1);
        i_rx = 1'b0;
        repeat (4) @(negedge wb_clk);
        i_rx = 1'b1;
        repeat (3 * DIV) @(negedge wb_clk);
        check("t8_err", {31'd0, o_err}, 32'd0);
        check("t8_done", {31'd0, o_done}, 32'd0);
        send_byte(8'h00, 1'b1);
        send_word(32'h89ABCDEF);
        wait_done("t8_done2", 200);
        check("t8_nwr", 32'(wr_adr.size()), 32'd1);
        check_write("t8_w0", 0, 32'h0, 32'h89ABCDEF);
        check("t8_err2", {31'd0, o_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
